// File: rtl/vga_pkg.sv
// Shared VGA fill constants: screen geometry, colour width and test-pattern modes.
package vga_pkg;

    localparam int unsigned SCREEN_W      = 320;
    localparam int unsigned SCREEN_H      = 240;
    localparam int unsigned SCREEN_PIXELS = SCREEN_W * SCREEN_H;
    localparam int unsigned COLOUR_W      = 3;
    localparam int unsigned ADDR_W        = 17;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_VSTRIPE = 2'd2,
        PAT_HSPLIT  = 2'd3
    } pattern_e;

endpackage

// File: rtl/fill_pixel_plotter_if.sv
// Address-counter input stream and VGA-adapter plot outputs of the fill plotter.
interface fill_pixel_plotter_if #(
    parameter int unsigned ADDR_W   = vga_pkg::ADDR_W,
    parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W
);

    logic                counting;
    logic [ADDR_W-1:0]   result;
    logic [1:0]          mode;
    logic [COLOUR_W-1:0] fg_colour;
    logic [COLOUR_W-1:0] bg_colour;

    logic [8:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                done;
    logic                error;

    modport master (
        output counting, result, mode, fg_colour, bg_colour,
        input  x, y, colour, plot, done, error
    );

    modport slave (
        input  counting, result, mode, fg_colour, bg_colour,
        output x, y, colour, plot, done, error
    );

endinterface

// File: rtl/fill_pixel_plotter_pattern_colour.sv
// Combinational test-pattern colour for one screen coordinate.
module pattern_colour #(
    parameter int unsigned SCREEN_H = vga_pkg::SCREEN_H,
    parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W
) (
    input  logic [1:0]          mode,
    input  logic [8:0]          x,
    input  logic [7:0]          y,
    input  logic [COLOUR_W-1:0] fg,
    input  logic [COLOUR_W-1:0] bg,
    output logic [COLOUR_W-1:0] colour
);

    import vga_pkg::*;

    localparam logic [7:0] SPLIT_ROW = 8'(SCREEN_H / 2);

    // Only x[4:3] select the checker/stripe phase.
    logic unused_x;
    assign unused_x = ^{x[8:5], x[2:0]};

    always_comb begin
        colour = fg;
        unique case (pattern_e'(mode))
            PAT_SOLID:   colour = fg;
            PAT_CHECKER: colour = (x[3] ^ y[3]) ? fg : bg;
            PAT_VSTRIPE: colour = x[4] ? fg : bg;
            PAT_HSPLIT:  colour = (y < SPLIT_ROW) ? fg : bg;
        endcase
    end

endmodule

// File: rtl/fill_pixel_plotter.sv
// Tracks (x,y) from the linear fill address stream, colours it and drives the VGA plot strobe.
module fill_pixel_plotter #(
    parameter int unsigned SCREEN_W = vga_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = vga_pkg::SCREEN_H,
    parameter int unsigned ADDR_W   = vga_pkg::ADDR_W,
    parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W
) (
    input logic                 clk,
    input logic                 reset,
    fill_pixel_plotter_if.slave bus
);

    import vga_pkg::*;

    localparam logic [8:0]        X_LAST     = 9'(SCREEN_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(SCREEN_W * SCREEN_H);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    logic                prev_counting_q;
    logic [ADDR_W-1:0]   last_addr_q;
    logic [8:0]          trk_x_q, trk_x_d;
    logic [7:0]          trk_y_q, trk_y_d;
    logic                error_q, error_d;

    logic [1:0]          mode_q;
    logic [COLOUR_W-1:0] fg_q, bg_q;

    logic                s1_valid_q, s1_valid_d;
    logic [8:0]          s1_x_q;
    logic [7:0]          s1_y_q;

    logic                end_d1_q;
    logic                done_q;
    logic                plot_q;
    logic [8:0]          x_q;
    logic [7:0]          y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic [COLOUR_W-1:0] pat_colour;

    logic run_start, run_end, accept, seq_ok, in_range;

    assign run_start = bus.counting & ~prev_counting_q;
    assign run_end   = ~bus.counting & prev_counting_q;
    // A held address (e.g. the counter parking on 0) is not a new pixel.
    assign accept    = bus.counting & (run_start | (bus.result != last_addr_q));
    assign seq_ok    = run_start ? (bus.result == '0)
                                 : (bus.result == last_addr_q + ADDR_ONE);
    assign in_range  = bus.result < ADDR_LIMIT;

    always_comb begin
        trk_x_d    = trk_x_q;
        trk_y_d    = trk_y_q;
        error_d    = run_start ? 1'b0 : error_q;
        s1_valid_d = 1'b0;
        if (accept) begin
            if (run_start) begin
                trk_x_d = '0;
                trk_y_d = '0;
            end else if (trk_x_q == X_LAST) begin
                trk_x_d = '0;
                trk_y_d = trk_y_q + 8'd1;
            end else begin
                trk_x_d = trk_x_q + 9'd1;
            end
            if (!seq_ok || !in_range) begin
                error_d = 1'b1;
            end
            // Once the stream has gone wrong, nothing more is plotted this run.
            s1_valid_d = ~error_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_counting_q <= 1'b0;
            last_addr_q     <= '0;
            trk_x_q         <= '0;
            trk_y_q         <= '0;
            error_q         <= 1'b0;
            mode_q          <= '0;
            fg_q            <= '0;
            bg_q            <= '0;
            s1_valid_q      <= 1'b0;
            s1_x_q          <= '0;
            s1_y_q          <= '0;
        end else begin
            prev_counting_q <= bus.counting;
            if (accept) begin
                last_addr_q <= bus.result;
            end
            trk_x_q    <= trk_x_d;
            trk_y_q    <= trk_y_d;
            error_q    <= error_d;
            if (run_start) begin
                mode_q <= bus.mode;
                fg_q   <= bus.fg_colour;
                bg_q   <= bus.bg_colour;
            end
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= trk_x_d;
            s1_y_q     <= trk_y_d;
        end
    end

    pattern_colour #(
        .SCREEN_H (SCREEN_H),
        .COLOUR_W (COLOUR_W)
    ) u_pattern_colour (
        .mode   (mode_q),
        .x      (s1_x_q),
        .y      (s1_y_q),
        .fg     (fg_q),
        .bg     (bg_q),
        .colour (pat_colour)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            end_d1_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            plot_q <= s1_valid_q;
            if (s1_valid_q) begin
                x_q      <= s1_x_q;
                y_q      <= s1_y_q;
                colour_q <= pat_colour;
            end
            // Two-cycle delay lets the last pixel leave the pipeline before done.
            end_d1_q <= run_end;
            done_q   <= end_d1_q;
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.done   = done_q;
    assign bus.error  = error_q;

endmodule

// File: tb/tb_fill_pixel_plotter.sv
// Scoreboard bench for fill_pixel_plotter: stimulus pushes expected pixels/done cycles, a monitor checks.
module tb_fill_pixel_plotter;

    typedef struct {
        int test;
        int addr;
        int x;
        int y;
        int col;
        int cyc;
    } exp_t;

    typedef struct {
        int test;
        int addr;
        int x;
        int y;
        int col;
    } spot_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fill_pixel_plotter_if bus ();

    fill_pixel_plotter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int plot_cnt = 0;
    int done_cnt = 0;
    int cur_test = 0;

    exp_t exp_q[$];
    int   done_q[$];
    spot_t spots[$];

    // Reference model state
    bit m_prev = 0;
    int m_last = 0;
    bit m_bad  = 0;
    int m_mode = 0;
    int m_fg   = 0;
    int m_bg   = 0;

    function automatic int model_col(int mode, int px, int py, int fg, int bg);
        case (mode)
            0:       return fg;
            1:       return (((px >> 3) ^ (py >> 3)) & 1) != 0 ? fg : bg;
            2:       return ((px >> 4) & 1) != 0 ? fg : bg;
            default: return (py < 120) ? fg : bg;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // One clock cycle of counter output; called just after a rising edge.
    task automatic step(input bit c, input int a);
        bit start;
        bit acc;
        bus.counting = c;
        bus.result   = a[16:0];
        start = c && !m_prev;
        if (!c && m_prev) done_q.push_back(cyc + 2);
        if (start) begin
            m_mode = int'(bus.mode);
            m_fg   = int'(bus.fg_colour);
            m_bg   = int'(bus.bg_colour);
            m_bad  = 0;
        end
        acc = c && (start || a != m_last);
        if (acc) begin
            if ((start ? (a != 0) : (a != m_last + 1)) || a >= 76800) m_bad = 1;
            if (!m_bad)
                exp_q.push_back('{cur_test, a, a % 320, a / 320,
                                  model_col(m_mode, a % 320, a / 320, m_fg, m_bg), cyc + 2});
            m_last = a;
        end
        m_prev = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic set_run(input int mode, input int fg, input int bg);
        bus.mode      = mode[1:0];
        bus.fg_colour = fg[2:0];
        bus.bg_colour = bg[2:0];
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.plot) begin
                plot_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_plot: got (%0d,%0d) col %0d, want no plot (t=%0t)",
                             bus.x, bus.y, bus.colour, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(bus.x) != e.x || int'(bus.y) != e.y ||
                        int'(bus.colour) != e.col || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL plot addr %0d: got (%0d,%0d) col %0d cyc %0d, want (%0d,%0d) col %0d cyc %0d",
                                 e.addr, bus.x, bus.y, bus.colour, cyc, e.x, e.y, e.col, e.cyc);
                    end
                    foreach (spots[i]) begin
                        if (spots[i].test == e.test && spots[i].addr == e.addr) begin
                            n_cmp++;
                            if (int'(bus.x) != spots[i].x || int'(bus.y) != spots[i].y ||
                                int'(bus.colour) != spots[i].col) begin
                                n_bad++;
                                $display("FAIL spot addr %0d: got (%0d,%0d) col %0d, want (%0d,%0d) col %0d",
                                         e.addr, bus.x, bus.y, bus.colour,
                                         spots[i].x, spots[i].y, spots[i].col);
                            end
                        end
                    end
                end
            end
            if (bus.done) begin
                done_cnt++;
                n_cmp++;
                if (done_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: got done at cyc %0d, want none", cyc);
                end else if (done_q[0] != cyc) begin
                    n_bad++;
                    $display("FAIL done_cycle: got cyc %0d, want cyc %0d", cyc, done_q[0]);
                    void'(done_q.pop_front());
                end else begin
                    void'(done_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Hand-computed coordinates/colours at notable addresses
        spots.push_back('{1, 0, 0, 0, 4});
        spots.push_back('{1, 319, 319, 0, 4});
        spots.push_back('{1, 320, 0, 1, 4});
        spots.push_back('{1, 76799, 319, 239, 4});
        spots.push_back('{2, 0, 0, 0, 3});
        spots.push_back('{2, 16, 16, 0, 6});
        spots.push_back('{3, 0, 0, 0, 1});
        spots.push_back('{3, 8, 8, 0, 2});
        spots.push_back('{3, 16, 16, 0, 1});
        spots.push_back('{3, 328, 8, 1, 2});
        spots.push_back('{3, 336, 16, 1, 1});
        spots.push_back('{4, 2, 2, 0, 7});
        spots.push_back('{7, 0, 0, 0, 5});

        bus.counting  = 1'b0;
        bus.result    = '0;
        set_run(0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_x", int'(bus.x), 0);
        check("reset_y", int'(bus.y), 0);
        check("reset_colour", int'(bus.colour), 0);
        check("reset_plot", int'(bus.plot), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_error", int'(bus.error), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Held start: 0 presented twice, mode 2 stripes
        cur_test = 2; plot_cnt = 0; done_cnt = 0;
        set_run(2, 6, 3);
        step(1'b1, 0);
        step(1'b1, 0);
        for (int a = 1; a < 50; a++) step(1'b1, a);
        step(1'b0, 0);
        idle(4);
        check("held_plot_count", plot_cnt, 50);
        check("held_done_count", done_cnt, 1);
        check("held_error", int'(bus.error), 0);

        // Checker, mode flipped mid-run; then one low cycle into a broken stream
        cur_test = 3; plot_cnt = 0; done_cnt = 0;
        set_run(1, 2, 1);
        for (int a = 0; a < 400; a++) begin
            if (a == 200) bus.mode = 2'd0;
            step(1'b1, a);
        end
        step(1'b0, 0);
        cur_test = 4;
        set_run(3, 7, 0);
        step(1'b1, 0);
        step(1'b1, 1);
        step(1'b1, 2);
        check("disc_error_before", int'(bus.error), 0);
        step(1'b1, 5);
        check("disc_error_after5", int'(bus.error), 1);
        step(1'b1, 6);
        step(1'b0, 0);
        idle(4);
        check("checker_disc_plot_count", plot_cnt, 403);
        check("checker_disc_done_count", done_cnt, 2);
        check("disc_error_sticky", int'(bus.error), 1);

        // Next run start clears error
        cur_test = 5; plot_cnt = 0; done_cnt = 0;
        set_run(0, 5, 0);
        step(1'b1, 0);
        check("error_cleared", int'(bus.error), 0);
        for (int a = 1; a < 10; a++) step(1'b1, a);
        step(1'b0, 0);
        idle(4);
        check("clear_plot_count", plot_cnt, 10);
        check("clear_done_count", done_cnt, 1);

        // Reset mid-run at address 1000, released with counting still high
        cur_test = 6;
        for (int a = 0; a <= 1000; a++) step(1'b1, a);
        reset = 1'b1;
        #1;
        check("midreset_plot", int'(bus.plot), 0);
        check("midreset_done", int'(bus.done), 0);
        check("midreset_error", int'(bus.error), 0);
        check("midreset_x", int'(bus.x), 0);
        check("midreset_y", int'(bus.y), 0);
        exp_q.delete();
        done_q.delete();
        m_prev = 0; m_last = 0; m_bad = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        plot_cnt = 0; done_cnt = 0;
        for (int a = 1001; a < 1006; a++) begin
            step(1'b1, a);
            check("postreset_error", int'(bus.error), 1);
        end
        step(1'b0, 0);
        idle(4);
        check("postreset_plot_count", plot_cnt, 0);
        check("postreset_done_count", done_cnt, 1);

        cur_test = 7; plot_cnt = 0; done_cnt = 0;
        set_run(0, 5, 2);
        for (int a = 0; a < 20; a++) step(1'b1, a);
        step(1'b0, 0);
        idle(4);
        check("refill_plot_count", plot_cnt, 20);
        check("refill_error", int'(bus.error), 0);

        // Full screen fill that overruns to 80000 addresses
        cur_test = 1; plot_cnt = 0; done_cnt = 0;
        set_run(0, 4, 3);
        for (int a = 0; a < 80000; a++) begin
            step(1'b1, a);
            if (a == 76799) check("fill_error_at_last", int'(bus.error), 0);
            if (a == 76800) check("fill_error_overrun", int'(bus.error), 1);
        end
        step(1'b0, 0);
        idle(4);
        check("fill_plot_count", plot_cnt, 76800);
        check("fill_done_count", done_cnt, 1);
        check("fill_error_sticky", int'(bus.error), 1);

        check("pending_pixels", exp_q.size(), 0);
        check("pending_done", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fill_pixel_plotter.md
Name: fill_pixel_plotter

Overview:
- Downstream stage of the linear pixel-address counter in the VGA compatibility test.
- Consumes the counter's `counting` flag and 17-bit linear address `result`, and tracks the matching (x,y) screen coordinate incrementally, with no divider.
- Generates a test-pattern colour and drives the VGA adapter's plot interface.
- Signals completion of a fill run and flags address-stream anomalies.

Parameters:
- SCREEN_W, 320, pixels per row; x wraps at this value.
- SCREEN_H, 240, rows per frame.
- ADDR_W, 17, width of the linear address input.
- COLOUR_W, 3, VGA adapter colour width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- counting  input  1  run-active flag from the address counter.
- result  input  ADDR_W  linear pixel address from the counter.
- mode  input  2  pattern select, sampled at run start.
- fg_colour  input  COLOUR_W  foreground colour, sampled at run start.
- bg_colour  input  COLOUR_W  background colour, sampled at run start.
- x  output  9  plot column.
- y  output  8  plot row.
- colour  output  COLOUR_W  plot colour.
- plot  output  1  write strobe to the VGA adapter, one pixel per cycle.
- done  output  1  one-cycle pulse once the final pixel of a run has been plotted.
- error  output  1  sticky; set on an address discontinuity or an out-of-range address; cleared at the next run start.

Behaviour:
- Reset (async, active-high):
  - x, y, colour, plot, done, error all 0.
  - Internal valid bits, prev_counting, last_addr and the x/y trackers cleared.
- Run start: the cycle in which counting=1 and prev_counting=0.
  - mode, fg_colour and bg_colour are latched into run registers.
  - error is cleared.
  - The tracker expects address 0. Changes to mode or colours mid-run have no effect.
- Accept rule: an address is new when counting=1 and either it is the run-start cycle or result != last_addr.
  - A repeated address (the counter holds 0 for an extra cycle when start is held) is dropped and never double-plotted.
- Stage 1 (tracking): for each new address A:
  - A==0 at run start: tracker (x,y) set to (0,0).
  - A==last_addr+1: x increments; if x==SCREEN_W-1, x goes to 0 and y increments.
  - Any other value: error is set, plotting is suppressed for the rest of the run, and last_addr still updates.
  - A >= SCREEN_W*SCREEN_H: error is set and plotting is suppressed for the rest of the run.
- Stage 2 (colour, registered outputs), by latched mode:
  - 0: solid fg.
  - 1: 8x8 checker; fg when x[3]^y[3], else bg.
  - 2: 16-px vertical stripes; fg when x[4], else bg.
  - 3: split; fg when y < SCREEN_H/2, else bg.
- Latency: an address accepted at cycle n gives plot=1 with its x, y and colour at cycle n+2. Throughput is 1 pixel/cycle.
- done:
  - Run end is the cycle with counting=0 and prev_counting=1; done pulses for 1 cycle exactly 2 cycles later, after the pipeline has drained.
  - done fires even when error=1.
- Simultaneous run end and new run start (counting low for 1 cycle): done still pulses, and the new run is tracked independently.
- Reset mid-run: everything clears immediately.
  - If counting is still high after reset release, that cycle is treated as a run start.
  - A nonzero result in that cycle sets error, so no partial fill is plotted.
- Width rule: tracker comparisons use ADDR_W bits; the x/y increment never exceeds the ranges above when the address stream is legal.

Decomposition:
- Shared vga_pkg holds:
  - SCREEN_W, SCREEN_H, SCREEN_PIXELS (=76800).
  - Pattern mode constants PAT_SOLID=0, PAT_CHECKER=1, PAT_VSTRIPE=2, PAT_HSPLIT=3.
  - COLOUR_W.
- One sub-module, pattern_colour: combinational mapping of (mode, x, y, fg, bg) to colour, registered by the parent.
- The address tracker stays inline.

Test Plan:
- Full fill:
  - Stimulus: counter limit=76800, 1-cycle start, mode 0, fg=3'b100.
  - Required response: exactly 76800 plot pulses, first at (0,0) 2 cycles after counting rises.
  - Addresses 319, 320 and 76799 map to (319,0), (0,1) and (319,239); colour is always 3'b100.
  - done pulses once; error stays 0.
- Held start:
  - Stimulus: start_count held 2 cycles, so result=0 is presented twice.
  - Required response: one plot at (0,0) and no duplicate; the total plot count still equals limit.
- Checker:
  - Stimulus: mode 1, fg=3'b010, bg=3'b001, limit=400.
  - Required response: addresses 0, 8, 16 and 328 give colours 001, 010, 001 and 010 (address 328 is (8,1)).
  - Flip mode to 0 mid-run: the pattern is unchanged.
- Discontinuity:
  - Stimulus: drive counting=1 with the sequence 0, 1, 2, 5, 6.
  - Required response: plots for addresses 0, 1 and 2 only; error=1 from the cycle after 5 is accepted.
  - done still pulses; error clears at the next run start.
- Out of range:
  - Stimulus: limit=80000.
  - Required response: 76800 plots; error=1 once address 76800 is accepted; no plot with y>239.
- Reset mid-run:
  - Stimulus: assert reset at address 1000.
  - Required response: plot, done and error are 0 immediately.
  - A new run started from 0 afterwards plots from (0,0) normally.
